mvm_run_sequencer: RTL and testbench



---
 rtl/mvm_pkg.sv | 23 ++
 rtl/timeout_counter.sv | 33 +++
 rtl/mvm_run_sequencer.sv | 175 +++++++++++++++++
 tb/tb_mvm_run_sequencer.sv | 312 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mvm_pkg.sv
// Shared types and constants for the 8x8 matrix-vector run controller.
// Result rows sit directly after the A matrix and B vector in memory.
package mvm_pkg;

  localparam int N        = 8;
  localparam int ACC_W    = 24;
  localparam int RES_BASE = 9;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_LOAD    = 3'd1,
    S_COMPUTE = 3'd2,
    S_WRITE   = 3'd3,
    S_DONE    = 3'd4,
    S_ERR     = 3'd5
  } state_e;

  localparam logic [1:0] ERR_NONE    = 2'd0;
  localparam logic [1:0] ERR_LOAD    = 2'd1;
  localparam logic [1:0] ERR_COMPUTE = 2'd2;
  localparam logic [1:0] ERR_WRITE   = 2'd3;

endpackage

// File: rtl/timeout_counter.sv
// Saturating wait timer; expired while the count sits at TIMEOUT-1.
// clear has priority over enable.
module timeout_counter #(
  parameter int TIMEOUT = 4096
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int TW = $clog2(TIMEOUT);
  localparam logic [TW-1:0] LAST = TW'(TIMEOUT - 1);

  logic [TW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clear)
      cnt_d = '0;
    else if (enable && cnt_q != LAST)
      cnt_d = cnt_q + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

  assign expired = (cnt_q == LAST);

endmodule

// File: rtl/mvm_run_sequencer.sv
// Run controller: load, multiply, then write N result rows over Avalon-MM.
// Every wait state is guarded by a timeout that lands in ERR.
module mvm_run_sequencer
  import mvm_pkg::*;
#(
  parameter int TIMEOUT = 4096
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  output logic               busy,
  output logic               done,
  output logic               error,
  output logic [1:0]         err_code,
  output logic               ld_start,
  input  logic               ld_done,
  output logic               mac_start,
  input  logic               mac_done,
  input  logic [N*ACC_W-1:0] acc,
  output logic [31:0]        avm_address,
  output logic               avm_write,
  output logic [63:0]        avm_writedata,
  input  logic               avm_waitrequest,
  output logic [2:0]         dbg_state
);

  state_e            state_q, state_d;
  logic [1:0]        err_q, err_d;
  logic [2:0]        idx_q, idx_d;
  logic [ACC_W-1:0]  res_q [N];
  logic [ACC_W-1:0]  res_d [N];
  logic              ld_start_q, ld_start_d;
  logic              mac_start_q, mac_start_d;
  logic              wr_q, wr_d;
  logic [31:0]       addr_q, addr_d;
  logic [63:0]       wdata_q, wdata_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              error_q, error_d;

  logic accept;
  logic expired;
  logic tmr_clr;
  logic tmr_en;

  assign accept = wr_q & ~avm_waitrequest;

  always_comb begin
    state_d     = state_q;
    err_d       = err_q;
    idx_d       = idx_q;
    res_d       = res_q;
    ld_start_d  = 1'b0;
    mac_start_d = 1'b0;
    wr_d        = 1'b0;
    unique case (state_q)
      S_IDLE, S_DONE, S_ERR: begin
        if (start) begin
          state_d    = S_LOAD;
          err_d      = ERR_NONE;
          ld_start_d = 1'b1;
        end
      end
      S_LOAD: begin
        // ld_done may still be high from the last run
        if (!ld_start_q && ld_done) begin
          state_d     = S_COMPUTE;
          mac_start_d = 1'b1;
        end else if (expired) begin
          state_d = S_ERR;
          err_d   = ERR_LOAD;
        end
      end
      S_COMPUTE: begin
        if (!mac_start_q && mac_done) begin
          for (int i = 0; i < N; i++)
            res_d[i] = acc[i*ACC_W +: ACC_W];
          idx_d   = '0;
          state_d = S_WRITE;
          wr_d    = 1'b1;
        end else if (expired) begin
          state_d = S_ERR;
          err_d   = ERR_COMPUTE;
        end
      end
      S_WRITE: begin
        wr_d = 1'b1;
        if (accept) begin
          if (idx_q == 3'(N - 1)) begin
            state_d = S_DONE;
            wr_d    = 1'b0;
          end else begin
            idx_d = idx_q + 3'd1;
          end
        end else if (expired) begin
          state_d = S_ERR;
          err_d   = ERR_WRITE;
          wr_d    = 1'b0;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_comb begin
    addr_d  = '0;
    wdata_d = '0;
    if (wr_d) begin
      addr_d  = 32'(RES_BASE) + 32'(idx_d);
      wdata_d = {{(64-ACC_W){1'b0}}, res_d[idx_d]};
    end
    busy_d  = (state_d == S_LOAD) || (state_d == S_COMPUTE)
           || (state_d == S_WRITE);
    done_d  = (state_d == S_DONE);
    error_d = (state_d == S_ERR);
    tmr_clr = (state_d != state_q) || accept;
    tmr_en  = busy_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      err_q       <= ERR_NONE;
      idx_q       <= '0;
      ld_start_q  <= 1'b0;
      mac_start_q <= 1'b0;
      wr_q        <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      error_q     <= 1'b0;
      for (int i = 0; i < N; i++)
        res_q[i] <= '0;
    end else begin
      state_q     <= state_d;
      err_q       <= err_d;
      idx_q       <= idx_d;
      ld_start_q  <= ld_start_d;
      mac_start_q <= mac_start_d;
      wr_q        <= wr_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      error_q     <= error_d;
      for (int i = 0; i < N; i++)
        res_q[i] <= res_d[i];
    end
  end

  timeout_counter #(
    .TIMEOUT (TIMEOUT)
  ) u_tmr (
    .clk     (clk),
    .rst     (rst),
    .clear   (tmr_clr),
    .enable  (tmr_en),
    .expired (expired)
  );

  assign busy          = busy_q;
  assign done          = done_q;
  assign error         = error_q;
  assign err_code      = err_q;
  assign ld_start      = ld_start_q;
  assign mac_start     = mac_start_q;
  assign avm_address   = addr_q;
  assign avm_write     = wr_q;
  assign avm_writedata = wdata_q;
  assign dbg_state     = state_q;

endmodule

// File: tb/tb_mvm_run_sequencer.sv
// Directed bench: default-timeout instance for runs, TIMEOUT=16 instance
// for the timeout paths; both share the same stimulus.
module tb_mvm_run_sequencer;

  localparam int N = 8;
  localparam int AW = 24;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          start = 1'b0;
  logic          ld_done = 1'b0;
  logic          mac_done = 1'b0;
  logic          waitreq = 1'b0;
  logic [N*AW-1:0] acc = '0;

  logic        busy, done, error, ld_start, mac_start, avm_write;
  logic [1:0]  err_code;
  logic [31:0] avm_address;
  logic [63:0] avm_writedata;
  logic [2:0]  dbg_state;

  logic        t_busy, t_done, t_error, t_ld, t_mac, t_wr;
  logic [1:0]  t_err;
  logic [31:0] t_addr;
  logic [63:0] t_wd;
  logic [2:0]  t_state;

  int npass = 0;
  int ntot = 0;
  int cyc = 0;
  int n_ld = 0;
  int n_mac = 0;
  int n_tacc = 0;
  int stall [N];
  logic [31:0] q_addr [$];
  logic [63:0] q_data [$];
  int          q_cyc  [$];

  always #5 clk = ~clk;

  mvm_run_sequencer u_dut (
    .clk(clk), .rst(rst), .start(start),
    .busy(busy), .done(done), .error(error), .err_code(err_code),
    .ld_start(ld_start), .ld_done(ld_done),
    .mac_start(mac_start), .mac_done(mac_done), .acc(acc),
    .avm_address(avm_address), .avm_write(avm_write),
    .avm_writedata(avm_writedata), .avm_waitrequest(waitreq),
    .dbg_state(dbg_state)
  );

  mvm_run_sequencer #(.TIMEOUT(16)) u_to (
    .clk(clk), .rst(rst), .start(start),
    .busy(t_busy), .done(t_done), .error(t_error), .err_code(t_err),
    .ld_start(t_ld), .ld_done(ld_done),
    .mac_start(t_mac), .mac_done(mac_done), .acc(acc),
    .avm_address(t_addr), .avm_write(t_wr),
    .avm_writedata(t_wd), .avm_waitrequest(waitreq),
    .dbg_state(t_state)
  );

  always @(posedge clk) begin
    cyc++;
    if (ld_start) n_ld++;
    if (mac_start) n_mac++;
    if (avm_write && !waitreq) begin
      q_addr.push_back(avm_address);
      q_data.push_back(avm_writedata);
      q_cyc.push_back(cyc);
    end
    if (t_wr && !waitreq) n_tacc++;
  end

  task automatic chk(input string tag, input logic [63:0] got,
                     input logic [63:0] exp);
    ntot++;
    if (got === exp) npass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_start();
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  task automatic clr_mon();
    q_addr.delete();
    q_data.delete();
    q_cyc.delete();
    n_ld = 0;
    n_mac = 0;
    n_tacc = 0;
  endtask

  task automatic set_acc(input int base);
    for (int i = 0; i < N; i++)
      acc[i*AW +: AW] = AW'(base + i*16 + 1);
  endtask

  task automatic wait_state(input string tag, input logic [2:0] s,
                            input int max);
    int n = 0;
    while (dbg_state != s && n < max) begin
      step();
      n++;
    end
    chk(tag, 64'(dbg_state), 64'(s));
  endtask

  // Drives waitrequest per row and checks address/data every write cycle.
  task automatic write_rows(input int base);
    int row = 0;
    int left = stall[0];
    int guard = 0;
    while (row < N && guard < 200) begin
      if (avm_write) begin
        chk("wr_addr", 64'(avm_address), 64'(9 + row));
        chk("wr_data", avm_writedata, 64'(base + row*16 + 1));
        if (left > 0) begin
          waitreq = 1'b1;
          left--;
        end else begin
          waitreq = 1'b0;
          row++;
          if (row < N) left = stall[row];
        end
      end
      step();
      guard++;
    end
    waitreq = 1'b0;
    chk("wr_guard", 64'(guard < 200), 64'd1);
  endtask

  task automatic chk_queue(input int base, input logic consec);
    chk("n_accept", 64'(q_addr.size()), 64'd8);
    for (int i = 0; i < N && i < q_addr.size(); i++) begin
      chk("acc_addr", 64'(q_addr[i]), 64'(9 + i));
      chk("acc_data", q_data[i], 64'(base + i*16 + 1));
      if (consec) chk("acc_cyc", 64'(q_cyc[i] - q_cyc[0]), 64'(i));
    end
  endtask

  task automatic chk_idle_zero(input string tag);
    chk({tag, "_state"}, 64'(dbg_state), 64'd0);
    chk({tag, "_busy"}, 64'(busy), 64'd0);
    chk({tag, "_done"}, 64'(done), 64'd0);
    chk({tag, "_error"}, 64'(error), 64'd0);
    chk({tag, "_err"}, 64'(err_code), 64'd0);
    chk({tag, "_ld"}, 64'(ld_start), 64'd0);
    chk({tag, "_mac"}, 64'(mac_start), 64'd0);
    chk({tag, "_wr"}, 64'(avm_write), 64'd0);
    chk({tag, "_addr"}, 64'(avm_address), 64'd0);
    chk({tag, "_wd"}, avm_writedata, 64'd0);
  endtask

  task automatic full_run(input int base, input int ld_dly,
                          input int mac_dly, input logic consec);
    set_acc(base);
    clr_mon();
    do_start();
    chk("run_ld_start", 64'(ld_start), 64'd1);
    chk("run_load", 64'(dbg_state), 64'd1);
    chk("run_done_clr", 64'(done), 64'd0);
    for (int i = 0; i < ld_dly; i++) begin
      start = (i >= 5 && i <= 8);
      step();
    end
    start = 1'b0;
    chk("busy_ignore", 64'(dbg_state), 64'd1);
    ld_done = 1'b1;
    wait_state("to_compute", 3'd2, 10);
    ld_done = 1'b0;
    chk("run_mac_start", 64'(mac_start), 64'd1);
    repeat (mac_dly) step();
    mac_done = 1'b1;
    step();
    mac_done = 1'b0;
    chk("wr_latency", 64'(avm_write), 64'd1);
    write_rows(base);
    chk("run_done", 64'(done), 64'd1);
    chk("run_busy", 64'(busy), 64'd0);
    chk("run_wr_off", 64'(avm_write), 64'd0);
    chk_queue(base, consec);
    chk("n_ld", 64'(n_ld), 64'd1);
    chk("n_mac", 64'(n_mac), 64'd1);
  endtask

  initial begin
    for (int i = 0; i < N; i++) stall[i] = 0;
    repeat (2) step();
    chk_idle_zero("rst");
    rst = 1'b0;
    step();

    // nominal run with start held while busy
    full_run(0, 80, 20, 1'b1);

    // backpressure, started from DONE
    stall[2] = 3;
    stall[7] = 5;
    full_run(32'h200, 4, 3, 1'b0);
    stall[2] = 0;
    stall[7] = 0;

    // load timeout on the TIMEOUT=16 instance
    rst = 1'b1;
    step();
    rst = 1'b0;
    do_start();
    chk("to1_load", 64'(t_state), 64'd1);
    repeat (15) step();
    chk("to1_still", 64'(t_state), 64'd1);
    chk("to1_noerr", 64'(t_error), 64'd0);
    step();
    chk("to1_state", 64'(t_state), 64'd5);
    chk("to1_error", 64'(t_error), 64'd1);
    chk("to1_code", 64'(t_err), 64'd1);
    chk("to1_busy", 64'(t_busy), 64'd0);

    // compute timeout, restart from ERR with stale ld_done
    ld_done = 1'b1;
    do_start();
    chk("re_error", 64'(t_error), 64'd0);
    chk("re_code", 64'(t_err), 64'd0);
    chk("re_ld", 64'(t_ld), 64'd1);
    step();
    chk("to2_load2", 64'(t_state), 64'd1);
    step();
    chk("to2_comp", 64'(t_state), 64'd2);
    chk("to2_mac", 64'(t_mac), 64'd1);
    repeat (15) step();
    chk("to2_still", 64'(t_state), 64'd2);
    step();
    chk("to2_state", 64'(t_state), 64'd5);
    chk("to2_code", 64'(t_err), 64'd2);

    // write timeout
    mac_done = 1'b1;
    waitreq = 1'b1;
    do_start();
    repeat (4) step();
    chk("to3_write", 64'(t_state), 64'd3);
    chk("to3_wr", 64'(t_wr), 64'd1);
    repeat (15) step();
    chk("to3_still", 64'(t_state), 64'd3);
    step();
    chk("to3_state", 64'(t_state), 64'd5);
    chk("to3_code", 64'(t_err), 64'd3);
    chk("to3_wr_off", 64'(t_wr), 64'd0);

    // second run from ERR completes
    waitreq = 1'b0;
    clr_mon();
    do_start();
    chk("re2_error", 64'(t_error), 64'd0);
    chk("re2_code", 64'(t_err), 64'd0);
    for (int i = 0; i < 40 && !t_done; i++) step();
    chk("re2_done", 64'(t_done), 64'd1);
    chk("re2_accepts", 64'(n_tacc), 64'd8);

    // stale done levels on the default instance
    rst = 1'b1;
    step();
    rst = 1'b0;
    set_acc(32'h300);
    clr_mon();
    do_start();
    chk("st_c0", 64'(dbg_state), 64'd1);
    step();
    chk("st_c1", 64'(dbg_state), 64'd1);
    step();
    chk("st_c2", 64'(dbg_state), 64'd2);
    step();
    chk("st_c3", 64'(dbg_state), 64'd2);
    step();
    chk("st_c4", 64'(dbg_state), 64'd3);
    write_rows(32'h300);
    chk("st_done", 64'(done), 64'd1);
    chk("st_n_ld", 64'(n_ld), 64'd1);
    chk("st_n_mac", 64'(n_mac), 64'd1);
    chk_queue(32'h300, 1'b1);

    // reset at row 4, then a full run from address 9
    ld_done = 1'b0;
    mac_done = 1'b0;
    set_acc(32'h500);
    clr_mon();
    ld_done = 1'b1;
    mac_done = 1'b1;
    do_start();
    for (int i = 0; i < 20 && avm_address != 32'd13; i++) step();
    chk("mid_row4", 64'(avm_address), 64'd13);
    rst = 1'b1;
    step();
    chk_idle_zero("mid");
    rst = 1'b0;
    ld_done = 1'b0;
    mac_done = 1'b0;
    step();
    full_run(32'h500, 3, 2, 1'b1);

    $display("%0d/%0d checks passed", npass, ntot);
    $finish;
  end

endmodule
